// File: rtl/effect_sample_driver_if.sv
// Sample handshake bundle: codec-side input, effect start/done channel and downstream output.
// The driver uses the master view; the surrounding environment uses the slave view.
interface effect_sample_driver_if #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned FIFO_DEPTH = 4
);
  logic                          in_ready;
  logic [DATA_W-1:0]             in_sample;
  logic                          enable;
  logic                          fx_start;
  logic [DATA_W-1:0]             fx_sample;
  logic                          fx_done;
  logic [DATA_W-1:0]             fx_result;
  logic                          out_valid;
  logic [DATA_W-1:0]             out_sample;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;
  logic                          timeout_err;

  modport master (
    input  in_ready, in_sample, enable, fx_done, fx_result,
    output fx_start, fx_sample, out_valid, out_sample, fifo_count, overflow, timeout_err
  );

  modport slave (
    output in_ready, in_sample, enable, fx_done, fx_result,
    input  fx_start, fx_sample, out_valid, out_sample, fifo_count, overflow, timeout_err
  );
endinterface

// File: rtl/effect_sample_driver.sv
// Queues codec samples and issues them one at a time to an effect via start/done,
// with bypass and a dry-sample fallback when the effect does not answer in time.
module effect_sample_driver #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 63
) (
  input logic                   clock,
  input logic                   reset,
  effect_sample_driver_if.master bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0] fx_sample_q, fx_sample_d;
  logic [DATA_W-1:0] out_sample_q, out_sample_d;
  logic              out_valid_q, out_valid_d;
  logic              timeout_err_q, timeout_set;
  logic              overflow_q;
  logic              fx_start;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              empty, full, pop, push_ok;
  logic [DATA_W-1:0] head;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign head    = mem_q[rd_ptr_q];
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok = bus.in_ready && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    fx_sample_d  = fx_sample_q;
    out_sample_d = out_sample_q;
    out_valid_d  = 1'b0;
    timeout_set  = 1'b0;
    pop          = 1'b0;
    fx_start     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop         = 1'b1;
          fx_sample_d = head;
          if (bus.enable) begin
            state_d = StIssue;
          end else begin
            out_sample_d = head;
            out_valid_d  = 1'b1;
          end
        end
      end
      StIssue: begin
        fx_start = 1'b1;
        timer_d  = '0;
        state_d  = StWait;
      end
      StWait: begin
        timer_d = timer_q + TW'(1);
        if (bus.fx_done) begin
          out_sample_d = bus.fx_result;
          out_valid_d  = 1'b1;
          state_d      = StIdle;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // Effect never answered: pass the dry sample through instead.
          out_sample_d = fx_sample_q;
          out_valid_d  = 1'b1;
          timeout_set  = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      fx_sample_q   <= '0;
      out_sample_q  <= '0;
      out_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      fx_sample_q  <= fx_sample_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      count_q      <= count_d;
      if (timeout_set) begin
        timeout_err_q <= 1'b1;
      end
      if (bus.in_ready && !push_ok) begin
        overflow_q <= 1'b1;
      end
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= bus.in_sample;
    end
  end

  assign bus.fx_start    = fx_start;
  assign bus.fx_sample   = fx_sample_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sample  = out_sample_q;
  assign bus.fifo_count  = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_effect_sample_driver.sv
// Bench for effect_sample_driver: cycle tables, directed corner sequences and a randomized
// run scored against a transaction-timeline model of the sample handshake.
module tb_effect_sample_driver;
  localparam int unsigned DATA_W     = 12;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned TIMEOUT    = 63;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  effect_sample_driver_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  effect_sample_driver #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit start_test;
    bit in_ready;
    int in_sample;
    bit enable;
    bit fx_done;
    int fx_result;
    bit exp_start;
    int exp_fx_sample;
    bit exp_valid;
    int exp_out;
    int exp_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit st, bit ir, int is, bit en, bit fd, int fr,
                              bit es, int efs, bit ev, int eo, int ec);
    vec_t v;
    v.start_test = st; v.in_ready = ir; v.in_sample = is; v.enable = en;
    v.fx_done = fd; v.fx_result = fr; v.exp_start = es; v.exp_fx_sample = efs;
    v.exp_valid = ev; v.exp_out = eo; v.exp_count = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sval(input logic [DATA_W-1:0] x);
    return int'($signed(x));
  endfunction

  task automatic drive(input bit ir, input int s, input bit en, input bit fd, input int r);
    bus.in_ready  = ir;
    bus.in_sample = s[DATA_W-1:0];
    bus.enable    = en;
    bus.fx_done   = fd;
    bus.fx_result = r[DATA_W-1:0];
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fx_start"}, bus.fx_start, 0);
    chk({tag, "_fx_sample"}, sval(bus.fx_sample), 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_sample"}, sval(bus.out_sample), 0);
    chk({tag, "_fifo_count"}, int'(bus.fifo_count), 0);
    chk({tag, "_overflow"}, bus.overflow, 0);
    chk({tag, "_timeout_err"}, bus.timeout_err, 0);
  endtask

  // Leaves the bench just after a clock edge with reset released: that is cycle 0.
  task automatic do_reset();
    drive(0, 0, 1, 0, 0);
    reset = 1'b0;
    step();
    chk_all_zero("reset");
    step();
    reset = 1'b1;
  endtask

  // Randomized run: model tracks the queue and the outstanding request as a timeline.
  task automatic random_run(input int n_cycles);
    int q[$];
    bit in_fx = 0;
    int issue_cyc = -1;
    int done_cyc = -1;
    int exp_cyc = -1;
    int exp_val = 0;
    int last_out = 0;
    int cur = 0;
    bit ovf = 0;
    bit tmo = 0;
    do_reset();
    for (int c = 0; c < n_cycles; c++) begin
      bit ir, en, fd;
      int s, r, pick;
      ir = ($urandom_range(0, 99) < 35);
      s  = int'($urandom_range(0, 4095)) - 2048;
      en = ($urandom_range(0, 3) != 0);
      r  = int'($urandom_range(0, 4095)) - 2048;
      fd = 1'b0;
      if (in_fx && c == done_cyc) fd = 1'b1;
      else if ((!in_fx || c == issue_cyc) && $urandom_range(0, 9) == 0) fd = 1'b1;
      drive(ir, s, en, fd, r);

      chk("rnd_fx_start", bus.fx_start, int'(in_fx && c == issue_cyc));
      if (in_fx) chk("rnd_fx_sample", sval(bus.fx_sample), cur);
      chk("rnd_out_valid", bus.out_valid, int'(c == exp_cyc));
      if (c == exp_cyc) last_out = exp_val;
      chk("rnd_out_sample", sval(bus.out_sample), last_out);
      chk("rnd_fifo_count", int'(bus.fifo_count), q.size());
      chk("rnd_overflow", bus.overflow, int'(ovf));
      chk("rnd_timeout_err", bus.timeout_err, int'(tmo));

      if (in_fx) begin
        if (c > issue_cyc) begin
          if (fd) begin
            exp_cyc = c + 1; exp_val = r; in_fx = 0;
          end else if (c - issue_cyc == int'(TIMEOUT)) begin
            exp_cyc = c + 1; exp_val = cur; tmo = 1; in_fx = 0;
          end
        end
      end else if (q.size() > 0) begin
        cur = q.pop_front();
        if (en) begin
          in_fx = 1;
          issue_cyc = c + 1;
          pick = int'($urandom_range(0, 29));
          if (pick == 0) done_cyc = -1;
          else if (pick == 1) done_cyc = issue_cyc + int'(TIMEOUT);
          else done_cyc = issue_cyc + int'($urandom_range(1, 10));
        end else begin
          exp_cyc = c + 1; exp_val = cur;
        end
      end
      if (ir) begin
        if (q.size() < int'(FIFO_DEPTH)) q.push_back(s);
        else ovf = 1;
      end
      step();
    end
  endtask

  initial begin
    int peak;
    int got[$];
    drive(0, 0, 1, 0, 0);

    // Basic effect round trip, then bypass of the most negative sample.
    for (int c = 0; c < 8; c++)
      vecs.push_back(mk(c == 0, c == 0, 100, 1, c == 5, -50,
                        c == 2, 100, c == 6, -50, (c == 1) ? 1 : 0));
    for (int c = 0; c < 5; c++)
      vecs.push_back(mk(c == 0, c == 0, -2048, 0, 0, 0,
                        0, 0, c == 2, -2048, (c == 1) ? 1 : 0));

    foreach (vecs[i]) begin
      if (vecs[i].start_test) do_reset();
      drive(vecs[i].in_ready, vecs[i].in_sample, vecs[i].enable,
            vecs[i].fx_done, vecs[i].fx_result);
      chk($sformatf("vec%0d_fx_start", i), bus.fx_start, int'(vecs[i].exp_start));
      if (vecs[i].exp_start)
        chk($sformatf("vec%0d_fx_sample", i), sval(bus.fx_sample), vecs[i].exp_fx_sample);
      chk($sformatf("vec%0d_out_valid", i), bus.out_valid, int'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_out_sample", i), sval(bus.out_sample), vecs[i].exp_out);
      chk($sformatf("vec%0d_fifo_count", i), int'(bus.fifo_count), vecs[i].exp_count);
      step();
    end

    // Overflow with a stalled responder, then in-order drain.
    do_reset();
    peak = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1, c + 1, 1, 0, 0);
      if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
      if (c == 5) chk("ovf_before_drop", bus.overflow, 0);
      step();
    end
    drive(0, 0, 1, 0, 0);
    if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_count_full", int'(bus.fifo_count), 4);
    chk("ovf_peak", peak, 4);
    for (int c = 0; c < 60; c++) begin
      drive(0, 0, 1, 1, sval(bus.fx_sample));
      if (bus.out_valid) got.push_back(sval(bus.out_sample));
      step();
    end
    chk("ovf_drain_n", got.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got.size()) chk($sformatf("ovf_drain%0d", i), got[i], i + 1);

    // Timeout fallback returns the dry sample.
    do_reset();
    for (int c = 0; c < 69; c++) begin
      drive(c == 0, 777, 1, 0, 0);
      chk($sformatf("to_valid_c%0d", c), bus.out_valid, int'(c == 66));
      if (c == 66) chk("to_out_sample", sval(bus.out_sample), 777);
      if (c == 65 || c == 66) chk($sformatf("to_err_c%0d", c), bus.timeout_err, int'(c == 66));
      step();
    end

    // fx_done on the last WAIT cycle beats the timeout.
    do_reset();
    for (int c = 0; c < 69; c++) begin
      drive(c == 0, 321, 1, c == 65, 5);
      chk($sformatf("last_valid_c%0d", c), bus.out_valid, int'(c == 66));
      if (c == 66) chk("last_out_sample", sval(bus.out_sample), 5);
      if (c >= 66) chk($sformatf("last_err_c%0d", c), bus.timeout_err, 0);
      step();
    end

    // Reset while waiting discards everything; a late fx_done is ignored.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1, (c + 1) * 10, 1, 0, 0);
      step();
    end
    drive(0, 0, 1, 0, 0);
    chk("mid_count_before", int'(bus.fifo_count), 3);
    reset = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    step();
    reset = 1'b1;
    step();
    for (int c = 6; c < 12; c++) begin
      drive(0, 0, 1, c == 6, 99);
      chk($sformatf("mid_valid_c%0d", c), bus.out_valid, 0);
      chk($sformatf("mid_start_c%0d", c), bus.fx_start, 0);
      chk($sformatf("mid_count_c%0d", c), int'(bus.fifo_count), 0);
      step();
    end

    random_run(4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
